// File: rtl/seq_div_ctrl_if.sv
// rtl/seq_div_ctrl_if.sv - operand/result handshake between operand source and divider
interface seq_div_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             dbz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dbz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dbz
    );
endinterface

// File: rtl/seq_div_ctrl.sv
// rtl/seq_div_ctrl.sv - restoring divider controller, one quotient bit per clock via external add/sub stage
// Optional abort input enabled by defining SEQ_DIV_CTRL_ABORT_EN.
module seq_div_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SEQ_DIV_CTRL_ABORT_EN
    input  logic             abort,
`endif
    seq_div_ctrl_if.slave    bus,
    output logic [WIDTH-1:0] as_a,
    output logic [WIDTH-1:0] as_b,
    output logic             as_sel,
    output logic             as_ci,
    input  logic [WIDTH-1:0] as_y,
    input  logic             as_co
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] q_r, d_r, r_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   shifted;
    logic             qbit;
    logic [WIDTH-1:0] r_nx;
    logic             last;
    logic             abort_i;

`ifdef SEQ_DIV_CTRL_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    // A set MSB in the shifted remainder means it already exceeds D; the wrapped
    // subtract result is still the correct (smaller than D) remainder.
    always_comb begin
        shifted = {r_r, q_r[WIDTH-1]};
        qbit    = shifted[WIDTH] | as_co;
        r_nx    = qbit ? as_y : shifted[WIDTH-1:0];
        last    = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.start) state_nx = (bus.divisor == '0) ? DONE : CALC;
            CALC: begin
                if (abort_i)   state_nx = IDLE;
                else if (last) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        as_a     = '0;
        as_b     = '0;
        as_sel   = 1'b0;
        as_ci    = 1'b0;
        case (state)
            CALC: begin
                bus.busy = 1'b1;
                as_a     = shifted[WIDTH-1:0];
                as_b     = d_r;
                as_sel   = 1'b1;
                as_ci    = 1'b1;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    // Published results (incl. dbz) move only when an operation completes, so an
    // aborted operation leaves the previous result visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r           <= '0;
            d_r           <= '0;
            r_r           <= '0;
            cnt           <= '0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.dbz       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor != '0) begin
                            q_r <= bus.dividend;
                            d_r <= bus.divisor;
                            r_r <= '0;
                            cnt <= '0;
                        end else begin
                            bus.quotient  <= '1;
                            bus.remainder <= bus.dividend;
                            bus.dbz       <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (!abort_i) begin
                        q_r <= {q_r[WIDTH-2:0], qbit};
                        r_r <= r_nx;
                        cnt <= cnt + CW'(1);
                        if (last) begin
                            bus.quotient  <= {q_r[WIDTH-2:0], qbit};
                            bus.remainder <= r_nx;
                            bus.dbz       <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_div_ctrl.sv
// tb/tb_seq_div_ctrl.sv - self-checking bench for seq_div_ctrl with a behavioural 4-bit add/sub stage
module tb_seq_div_ctrl;
    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] as_a, as_b, as_y;
    logic             as_sel, as_ci, as_co;
    logic [WIDTH:0]   as_sum;
`ifdef SEQ_DIV_CTRL_ABORT_EN
    logic             abort = 1'b0;
`endif

    seq_div_ctrl_if #(.WIDTH(WIDTH)) bus ();

    seq_div_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef SEQ_DIV_CTRL_ABORT_EN
        .abort  (abort),
`endif
        .bus    (bus),
        .as_a   (as_a),
        .as_b   (as_b),
        .as_sel (as_sel),
        .as_ci  (as_ci),
        .as_y   (as_y),
        .as_co  (as_co)
    );

    assign as_sum = {1'b0, as_a} + {1'b0, (as_sel ? ~as_b : as_b)} + {{WIDTH{1'b0}}, as_ci};
    assign as_y   = as_sum[WIDTH-1:0];
    assign as_co  = as_sum[WIDTH];

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a, b, q, r;
        logic             dbz;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] q, r;
        logic             dbz;
        int               lat, nbusy;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r, input logic dbz);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while ((bus.busy || bus.done) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("idle_timeout", 1, 0);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        e.q = q; e.r = r; e.dbz = dbz;
        e.lat   = (b == 0) ? 1 : WIDTH + 1;
        e.nbusy = (b == 0) ? 0 : WIDTH;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = ~a;
        bus.divisor  = ~b;
    endtask

    // Entered at the first sample after the acceptance edge.
    task automatic wait_done(input bit timing);
        exp_t e;
        int   lat, nb;
        bit   seen;
        lat = 1; nb = 0; seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.busy) nb++;
            if (bus.done) begin
                seen = 1;
                break;
            end
            lat++;
            @(posedge clk);
            #1;
        end
        check("done_seen", seen, 1);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            if (seen) begin
                check("quotient", bus.quotient, e.q);
                check("remainder", bus.remainder, e.r);
                check("dbz", bus.dbz, e.dbz);
                if (timing) begin
                    check("latency", lat, e.lat);
                    check("busy_cycles", nb, e.nbusy);
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;

        vecs[0] = '{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1, dbz: 1'b0};
        vecs[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, dbz: 1'b0};
        vecs[2] = '{a: 4'd7,  b: 4'd9,  q: 4'd0,  r: 4'd7, dbz: 1'b0};
        vecs[3] = '{a: 4'd14, b: 4'd7,  q: 4'd2,  r: 4'd0, dbz: 1'b0};
        vecs[4] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, dbz: 1'b0};
        vecs[5] = '{a: 4'd9,  b: 4'd0,  q: 4'd15, r: 4'd9, dbz: 1'b1};

        // Reset state
        #12;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_dbz", bus.dbz, 0);
        check("rst_as_a", as_a, 0);
        check("rst_as_sel", as_sel, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: 13/3 with first-iteration add/sub operands
        launch(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
        check("t1_as_a", as_a, 1);
        check("t1_as_b", as_b, 3);
        check("t1_as_sel", as_sel, 1);
        check("t1_as_ci", as_ci, 1);
        check("t1_q_held_in_calc", bus.quotient, 0);
        wait_done(1'b1);

        // Test 2/3: directed table, including divide by zero
        for (int i = 0; i < 6; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);
            wait_done(1'b1);
        end

        // Exhaustive sweep against a reference model
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [WIDTH-1:0] ea, eb;
                ea = 4'(a);
                eb = 4'(b);
                if (b == 0) launch(ea, eb, 4'hF, ea, 1'b1);
                else        launch(ea, eb, 4'(a / b), 4'(a % b), 1'b0);
                wait_done(1'b1);
            end
        end

        // Test 4: starts during CALC and DONE are ignored
        launch(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
        @(negedge clk);
        bus.dividend = 4'd7;
        bus.divisor  = 4'd2;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("t4_busy_after_calc_start", bus.busy, 1);
        @(posedge clk);
        #1;
        wait_done(1'b0);
        bus.dividend = 4'd8;
        bus.divisor  = 4'd2;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("t4_busy_after_done_start", bus.busy, 0);
        check("t4_done_once", bus.done, 0);
        check("t4_quotient_intact", bus.quotient, 4);
        check("t4_remainder_intact", bus.remainder, 1);
        @(posedge clk);
        #1;
        check("t4_no_queued_start", bus.busy, 0);
        launch(4'd6, 4'd3, 4'd2, 4'd0, 1'b0);
        wait_done(1'b1);

        // Test 5: asynchronous reset in the 2nd CALC cycle
        launch(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
        @(posedge clk);
        #1;
        check("t5_in_calc", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("t5_busy", bus.busy, 0);
        check("t5_done", bus.done, 0);
        check("t5_quotient", bus.quotient, 0);
        check("t5_remainder", bus.remainder, 0);
        check("t5_dbz", bus.dbz, 0);
        check("t5_as_a", as_a, 0);
        check("t5_as_b", as_b, 0);
        check("t5_as_sel", as_sel, 0);
        check("t5_as_ci", as_ci, 0);
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("t5_no_done_in_reset", bus.done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("t5_idle_after_reset", bus.busy | bus.done, 0);
        end
        launch(4'd6, 4'd4, 4'd1, 4'd2, 1'b0);
        wait_done(1'b1);

`ifdef SEQ_DIV_CTRL_ABORT_EN
        // Test 6: abort in CALC cycle 2 keeps the previous result
        launch(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
        wait_done(1'b1);
        launch(4'd10, 4'd3, 4'd3, 4'd1, 1'b0);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("t6_busy", bus.busy, 0);
        check("t6_quotient", bus.quotient, 4);
        check("t6_remainder", bus.remainder, 1);
        void'(sb.pop_front());
        for (int i = 0; i < 8; i++) begin
            check("t6_no_done", bus.done, 0);
            @(posedge clk);
            #1;
        end
        launch(4'd10, 4'd3, 4'd3, 4'd1, 1'b0);
        wait_done(1'b1);
`endif

        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
